// File: rtl/stack_mem_ctrl.sv
// Stack/data memory controller with a downward-growing hardware stack.
// One command is accepted when cmd_valid is high and the controller is idle.
// Single-access commands finish one cycle after acceptance. INTR and RTI take
// two accesses and finish two cycles after acceptance.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   cmd_valid, cmd  command request and opcode
//   addr            effective address for LOAD/STORE
//   wdata           data for STORE/PUSH/OUT
//   pc_in, ccr_in   program counter and flags saved by CALL/INTR
//   in_port         external input sampled by IN
//   busy, done      command in progress / one-cycle completion pulse
//   rdata, ccr_out  read result / flags restored by RTI (valid with done)
//   sp, out_port    stack pointer / latched output port
//   err             {addr_err, ovf, unf}, valid with done
module stack_mem_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned FLAG_W  = 4,
  parameter int unsigned DATA_LO = 156,
  parameter int unsigned DATA_HI = 199,
  parameter int unsigned STK_BOT = 200,
  parameter int unsigned STK_TOP = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [3:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [FLAG_W-1:0] ccr_in,
  input  logic [DATA_W-1:0] in_port,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [FLAG_W-1:0] ccr_out,
  output logic [ADDR_W-1:0] sp,
  output logic [DATA_W-1:0] out_port,
  output logic [2:0]        err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] DATA_LO_A = ADDR_W'(DATA_LO);
  localparam logic [ADDR_W-1:0] DATA_HI_A = ADDR_W'(DATA_HI);
  localparam logic [ADDR_W-1:0] SP_EMPTY  = ADDR_W'(STK_TOP);
  localparam logic [ADDR_W-1:0] SP_FULL   = ADDR_W'(STK_BOT - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_LOAD  = 4'd1;
  localparam logic [3:0] CMD_STORE = 4'd2;
  localparam logic [3:0] CMD_PUSH  = 4'd3;
  localparam logic [3:0] CMD_POP   = 4'd4;
  localparam logic [3:0] CMD_CALL  = 4'd5;
  localparam logic [3:0] CMD_RET   = 4'd6;
  localparam logic [3:0] CMD_INTR  = 4'd7;
  localparam logic [3:0] CMD_RTI   = 4'd8;
  localparam logic [3:0] CMD_IN    = 4'd9;
  localparam logic [3:0] CMD_OUT   = 4'd10;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [3:0]        cmd_q, cmd_n;
  logic [FLAG_W-1:0] ccr_q, ccr_lat_n;
  logic [ADDR_W-1:0] sp_n, sp_inc;
  logic [DATA_W-1:0] rdata_n, out_n;
  logic [FLAG_W-1:0] ccr_n;
  logic [2:0]        err_n;
  logic              done_n, busy_n;

  logic              push_en, pop_en, pop_to_ccr;
  logic [DATA_W-1:0] push_val, pop_val;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              in_data;

  assign sp_inc  = sp + ONE_A;
  assign pop_val = mem[sp_inc];
  assign in_data = (addr >= DATA_LO_A) && (addr <= DATA_HI_A);

  // Next-state, next-output and memory-access decode.
  always_comb begin
    state_n    = state;
    cmd_n      = cmd_q;
    ccr_lat_n  = ccr_q;
    sp_n       = sp;
    rdata_n    = rdata;
    ccr_n      = ccr_out;
    out_n      = out_port;
    err_n      = err;
    done_n     = 1'b0;
    push_en    = 1'b0;
    push_val   = '0;
    pop_en     = 1'b0;
    pop_to_ccr = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = sp;
    mem_wdata  = '0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n   = ACC1;
          cmd_n     = cmd;
          ccr_lat_n = ccr_in;
          err_n     = 3'b000;
          done_n    = 1'b1;
          case (cmd)
            CMD_LOAD: begin
              if (in_data) begin
                rdata_n = mem[addr];
              end else begin
                rdata_n  = '0;
                err_n[2] = 1'b1;
              end
            end
            CMD_STORE: begin
              if (in_data) begin
                mem_we    = 1'b1;
                mem_waddr = addr;
                mem_wdata = wdata;
              end else begin
                err_n[2] = 1'b1;
              end
            end
            CMD_PUSH: begin
              push_en  = 1'b1;
              push_val = wdata;
            end
            CMD_POP, CMD_RET: pop_en = 1'b1;
            CMD_CALL: begin
              push_en  = 1'b1;
              push_val = DATA_W'(ADDR_W'(pc_in + ONE_A));
            end
            CMD_INTR: begin
              push_en  = 1'b1;
              push_val = DATA_W'(pc_in);
              done_n   = 1'b0;
            end
            CMD_RTI: begin
              pop_en     = 1'b1;
              pop_to_ccr = 1'b1;
              done_n     = 1'b0;
            end
            CMD_IN:  rdata_n = in_port;
            CMD_OUT: out_n   = wdata;
            default: ;
          endcase
        end
      end
      ACC1: begin
        state_n = IDLE;
        // A second step runs only if the first one was not aborted (done low).
        if (((cmd_q == CMD_INTR) || (cmd_q == CMD_RTI)) && !done) begin
          state_n = ACC2;
          done_n  = 1'b1;
          if (cmd_q == CMD_INTR) begin
            push_en  = 1'b1;
            push_val = DATA_W'(ccr_q);
          end else begin
            pop_en = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Shared stack push: full stack suppresses the write and ends the command.
    if (push_en) begin
      if (sp == SP_FULL) begin
        err_n[1] = 1'b1;
        done_n   = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = sp;
        mem_wdata = push_val;
        sp_n      = sp - ONE_A;
      end
    end

    // Shared stack pop: empty stack returns zero and ends the command.
    if (pop_en) begin
      if (sp == SP_EMPTY) begin
        rdata_n  = '0;
        err_n[0] = 1'b1;
        done_n   = 1'b1;
      end else begin
        sp_n = sp_inc;
        if (pop_to_ccr) begin
          ccr_n = FLAG_W'(pop_val);
        end else begin
          rdata_n = pop_val;
        end
      end
    end

    if (done_n) begin
      state_n = (state == IDLE || state == ACC1) ? state_n : IDLE;
    end
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sp       <= SP_EMPTY;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      ccr_out  <= '0;
      out_port <= '0;
      err      <= 3'b000;
      cmd_q    <= CMD_NOP;
      ccr_q    <= '0;
    end else begin
      state    <= state_n;
      sp       <= sp_n;
      busy     <= busy_n;
      done     <= done_n;
      rdata    <= rdata_n;
      ccr_out  <= ccr_n;
      out_port <= out_n;
      err      <= err_n;
      cmd_q    <= cmd_n;
      ccr_q    <= ccr_lat_n;
    end
  end

  // Memory array: not reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
